// File: rtl/memory_arbiter_n.sv
// memory_arbiter_n: arbitrates NUM_PORTS line-request ports onto one memory bus with a
// single outstanding transaction, fixed-priority or round-robin, and routes the response back.
module memory_arbiter_n #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int LINE_SIZE = 256,
    parameter int RR_MODE   = 1,
    localparam int GW       = $clog2(NUM_PORTS)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_PORTS-1:0]           port_req_valid_i,
    input  logic [NUM_PORTS-1:0]           port_req_write_i,
    input  logic [NUM_PORTS*ADDR_SIZE-1:0] port_req_addr_i,
    input  logic [NUM_PORTS*LINE_SIZE-1:0] port_req_wdata_i,
    output logic [NUM_PORTS-1:0]           port_req_ready_o,
    output logic [NUM_PORTS-1:0]           port_rsp_valid_o,
    output logic [LINE_SIZE-1:0]           port_rsp_rdata_o,
    output logic                           mem_req_valid_o,
    output logic                           mem_req_write_o,
    output logic [ADDR_SIZE-1:0]           mem_req_addr_o,
    output logic [LINE_SIZE-1:0]           mem_req_wdata_o,
    input  logic                           mem_req_ready_i,
    input  logic                           mem_rsp_valid_i,
    input  logic [LINE_SIZE-1:0]           mem_rsp_rdata_i,
    output logic [GW-1:0]                  grant_o,
    output logic                           busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t                r_state, w_next;
    logic [GW-1:0]         r_rr_ptr, r_grant, w_win;
    logic [GW:0]           w_idx;
    logic                  w_found, w_done;
    logic                  r_write;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [LINE_SIZE-1:0]  r_wdata;

    // Descending scan so the first requester at or after rr_ptr is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            w_idx = {1'b0, r_rr_ptr} + (GW+1)'(i);
            if (w_idx >= (GW+1)'(NUM_PORTS)) w_idx = w_idx - (GW+1)'(NUM_PORTS);
            if (port_req_valid_i[w_idx[GW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[GW-1:0];
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        port_req_ready_o = '0;
        port_rsp_valid_o = '0;
        case (r_state)
            IDLE: if (reset_i && w_found) begin
                port_req_ready_o[w_win] = 1'b1;
                w_next                  = ISSUE;
            end
            ISSUE: if (mem_req_ready_i) begin
                port_rsp_valid_o[r_grant] = mem_rsp_valid_i;
                w_next                    = mem_rsp_valid_i ? IDLE : WAIT_RSP;
            end
            WAIT_RSP: if (mem_rsp_valid_i) begin
                port_rsp_valid_o[r_grant] = 1'b1;
                w_next                    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_done = |port_rsp_valid_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_grant <= w_win;
                r_write <= port_req_write_i[w_win];
                r_addr  <= port_req_addr_i[w_win*ADDR_SIZE +: ADDR_SIZE];
                r_wdata <= port_req_wdata_i[w_win*LINE_SIZE +: LINE_SIZE];
            end
            if (RR_MODE != 0 && w_done)
                r_rr_ptr <= (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + GW'(1);
        end
    end

    assign mem_req_valid_o  = (r_state == ISSUE);
    assign mem_req_write_o  = r_write;
    assign mem_req_addr_o   = r_addr;
    assign mem_req_wdata_o  = r_wdata;
    assign port_rsp_rdata_o = mem_rsp_rdata_i;
    assign grant_o          = r_grant;
    assign busy_o           = (r_state != IDLE);
endmodule

// File: tb/tb_memory_arbiter_n.sv
// tb_memory_arbiter_n: randomized scoreboard bench for a 3-port round-robin arbiter plus a
// 2-port fixed-priority instance checked for starvation of the lower-priority port.
module tb_memory_arbiter_n;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int LW = 64;
    localparam int GW = $clog2(N);
    localparam logic [LW-1:0] FP_D  = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [LW-1:0] FP_W0 = 64'h2222_2222_2222_2222;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0, req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*LW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [LW-1:0]   rsp_rdata, mwdata;
    logic            mvalid, mwrite, busy;
    logic [AW-1:0]   maddr;
    logic            mready = 1'b0, mrsp = 1'b0;
    logic [LW-1:0]   mrdata = '0;
    logic [GW-1:0]   grant;

    logic [1:0]    f_ready, f_rsp;
    logic [LW-1:0] f_rdata, f_mwdata;
    logic          f_mvalid, f_mwrite, f_grant, f_busy;
    logic [AW-1:0] f_maddr;

    memory_arbiter_n #(.NUM_PORTS(N), .ADDR_SIZE(AW), .LINE_SIZE(LW), .RR_MODE(1)) dut (
        .clk_i(clk), .reset_i(rst_n),
        .port_req_valid_i(req_valid), .port_req_write_i(req_write),
        .port_req_addr_i(req_addr), .port_req_wdata_i(req_wdata),
        .port_req_ready_o(req_ready), .port_rsp_valid_o(rsp_valid), .port_rsp_rdata_o(rsp_rdata),
        .mem_req_valid_o(mvalid), .mem_req_write_o(mwrite), .mem_req_addr_o(maddr),
        .mem_req_wdata_o(mwdata), .mem_req_ready_i(mready), .mem_rsp_valid_i(mrsp),
        .mem_rsp_rdata_i(mrdata), .grant_o(grant), .busy_o(busy)
    );

    memory_arbiter_n #(.NUM_PORTS(2), .ADDR_SIZE(AW), .LINE_SIZE(LW), .RR_MODE(0)) fp (
        .clk_i(clk), .reset_i(rst_n),
        .port_req_valid_i(2'b11), .port_req_write_i(2'b00),
        .port_req_addr_i({32'h0000_0080, 32'h0000_0040}),
        .port_req_wdata_i({64'h1111_1111_1111_1111, FP_W0}),
        .port_req_ready_o(f_ready), .port_rsp_valid_o(f_rsp), .port_rsp_rdata_o(f_rdata),
        .mem_req_valid_o(f_mvalid), .mem_req_write_o(f_mwrite), .mem_req_addr_o(f_maddr),
        .mem_req_wdata_o(f_mwdata), .mem_req_ready_i(1'b1), .mem_rsp_valid_i(1'b1),
        .mem_rsp_rdata_i(FP_D), .grant_o(f_grant), .busy_o(f_busy)
    );

    typedef struct { int port; logic w; logic [AW-1:0] a; logic [LW-1:0] d; } mreq_t;
    typedef struct { int port; logic [LW-1:0] d; } mrsp_t;
    mreq_t exp_mem[$];
    mrsp_t exp_rsp[$];

    bit            pv[N];
    logic          pw[N];
    logic [AW-1:0] pa[N];
    logic [LW-1:0] pd[N];
    int phase = 0, cur = 0, ptr = 0, rdy_cnt = 0, rsp_cnt = 0;
    logic [GW-1:0] mgrant = '0, exp_grant = '0;
    logic [N-1:0]  exp_ready = '0, ev;
    logic          exp_busy = 1'b0, exp_mvalid = 1'b0;
    int req_pct = 0, rw_min = 0, rw_max = 0, rd_min = 0, rd_max = 0, spur_pct = 0;
    logic [N-1:0]  req_mask = '0;
    bit            use_fix = 1'b0, mon_en = 1'b0, fp_en = 1'b0, fidle = 1'b0;
    logic [LW-1:0] fix_d = '0;
    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arbitration: first pending port at or after the pointer, wrapping.
    function automatic int winner();
        for (int i = 0; i < N; i++)
            if (pv[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic bit any_pv();
        for (int k = 0; k < N; k++) if (pv[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic complete();
        mrsp_t r;
        r.port = cur;
        r.d    = mrdata;
        exp_rsp.push_back(r);
        phase = 0;
        ptr   = (cur + 1) % N;
    endtask

    // One cycle of port and memory stimulus; model phase 0=idle, 1=issuing, 2=awaiting response.
    task automatic step();
        int w;
        mreq_t m;
        for (int k = 0; k < N; k++) begin
            if (!pv[k] && req_mask[k] && $urandom_range(99) < req_pct) begin
                pv[k] = 1'b1;
                pw[k] = 1'($urandom_range(1));
                pa[k] = $urandom;
                pd[k] = {$urandom, $urandom};
            end
            req_valid[k]            = pv[k];
            req_write[k]            = pw[k];
            req_addr[k*AW +: AW]    = pa[k];
            req_wdata[k*LW +: LW]   = pd[k];
        end
        exp_busy   = (phase != 0);
        exp_mvalid = (phase == 1);
        exp_grant  = mgrant;
        exp_ready  = '0;
        mready     = 1'b0;
        mrsp       = 1'b0;
        mrdata     = use_fix ? fix_d : {$urandom, $urandom};
        if (phase == 0) begin
            w = winner();
            if (w >= 0) begin
                exp_ready[w] = 1'b1;
                m.port = w; m.w = pw[w]; m.a = pa[w]; m.d = pd[w];
                exp_mem.push_back(m);
                cur     = w;
                mgrant  = GW'(w);
                pv[w]   = 1'b0;
                phase   = 1;
                rdy_cnt = $urandom_range(rw_max, rw_min);
            end
            mrsp = ($urandom_range(99) < spur_pct);
        end else if (phase == 1) begin
            if (rdy_cnt == 0) begin
                mready  = 1'b1;
                rsp_cnt = $urandom_range(rd_max, rd_min);
                if (rsp_cnt == 0) begin
                    mrsp = 1'b1;
                    complete();
                end else phase = 2;
            end else begin
                rdy_cnt--;
                mrsp = ($urandom_range(99) < spur_pct);
            end
        end else begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mrsp = 1'b1;
                complete();
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        step();
        mon_en = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain();
        int n = 0;
        while ((phase != 0 || any_pv()) && n < 200) begin
            cycle();
            n++;
        end
        if (phase != 0 || any_pv()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: model still busy after %0d cycles", n);
        end
    endtask

    task automatic reset_chk();
        chk("rst_ready", LW'(req_ready), '0);
        chk("rst_rsp_valid", LW'(rsp_valid), '0);
        chk("rst_busy", LW'(busy), '0);
        chk("rst_grant", LW'(grant), '0);
        chk("rst_mem_valid", LW'(mvalid), '0);
        chk("rst_mem_write", LW'(mwrite), '0);
        chk("rst_mem_addr", LW'(maddr), '0);
        chk("rst_mem_wdata", mwdata, '0);
    endtask

    always @(negedge clk) if (mon_en) begin
        chk("ready", LW'(req_ready), LW'(exp_ready));
        chk("busy", LW'(busy), LW'(exp_busy));
        chk("grant", LW'(grant), LW'(exp_grant));
        chk("mem_valid", LW'(mvalid), LW'(exp_mvalid));
        if (mvalid) begin
            if (exp_mem.size() == 0) chk("mem_req_unexpected", LW'(mvalid), '0);
            else begin
                chk("mem_write", LW'(mwrite), LW'(exp_mem[0].w));
                chk("mem_addr", LW'(maddr), LW'(exp_mem[0].a));
                chk("mem_wdata", mwdata, exp_mem[0].d);
                if (mready) void'(exp_mem.pop_front());
            end
        end
        ev = '0;
        if (exp_rsp.size() > 0) begin
            ev[exp_rsp[0].port] = 1'b1;
            chk("rsp_data", rsp_rdata, exp_rsp[0].d);
            void'(exp_rsp.pop_front());
        end
        chk("rsp_valid", LW'(rsp_valid), LW'(ev));
    end

    // Fixed priority with both ports always requesting and an instant memory alternates IDLE/ISSUE.
    always @(negedge clk) if (fp_en) begin
        chk("fp_ready", LW'(f_ready), fidle ? LW'(1) : '0);
        chk("fp_rsp", LW'(f_rsp), fidle ? '0 : LW'(1));
        chk("fp_busy", LW'(f_busy), LW'(!fidle));
        chk("fp_mvalid", LW'(f_mvalid), LW'(!fidle));
        chk("fp_grant", LW'(f_grant), '0);
        if (!fidle) begin
            chk("fp_addr", LW'(f_maddr), LW'(32'h40));
            chk("fp_write", LW'(f_mwrite), '0);
            chk("fp_wdata", f_mwdata, FP_W0);
            chk("fp_rdata", f_rdata, FP_D);
        end
        fidle = !fidle;
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            pv[k] = 1'b0; pw[k] = 1'b0; pa[k] = '0; pd[k] = '0;
        end
        req_valid = '1;
        mready    = 1'b1;
        mrsp      = 1'b1;
        #12;
        reset_chk();
        req_valid = '0;
        mready    = 1'b0;
        mrsp      = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 32'h100; pd[1] = '0;
        use_fix = 1'b1; fix_d = 64'hA5A5_A5A5_A5A5_A5A5;
        rd_min = 5; rd_max = 5;
        drain();
        use_fix = 1'b0;

        pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = 32'h40; pd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        rw_min = 3; rw_max = 3; rd_min = 2; rd_max = 2;
        drain();

        pv[2] = 1'b1; pw[2] = 1'b0; pa[2] = 32'h200;
        rw_min = 0; rw_max = 0; rd_min = 0; rd_max = 0;
        drain();

        req_mask = '1; req_pct = 100; rd_max = 2;
        run(30);
        req_pct = 0;
        drain();

        req_pct = 30; rw_max = 3; rd_max = 4; spur_pct = 20;
        run(300);
        req_pct = 0;
        drain();

        spur_pct = 0; rw_max = 0; rd_min = 1; rd_max = 1;
        pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 32'h300;
        drain();
        pv[1] = 1'b1; pa[1] = 32'h340; rd_min = 8; rd_max = 8;
        run(3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        mon_en    = 1'b0;
        req_valid = '1;
        mready    = 1'b1;
        mrsp      = 1'b1;
        #1;
        reset_chk();
        phase = 0; ptr = 0; mgrant = '0;
        exp_mem.delete();
        exp_rsp.delete();
        for (int k = 0; k < N; k++) pv[k] = 1'b0;
        req_valid = '0;
        mready    = 1'b0;
        mrsp      = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        fidle = 1'b0;
        fp_en = 1'b1;

        spur_pct = 100; rd_min = 0; rd_max = 2;
        run(4);
        spur_pct = 0; req_pct = 100;
        run(12);
        req_pct = 0;
        drain();
        run(4);
        fp_en  = 1'b0;
        mon_en = 1'b0;
        chk("exp_mem_empty", LW'(exp_mem.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_arbiter_n.md
# memory_arbiter_n

Parametrised N-port, line-granular arbiter between NUM_PORTS cache memory buses (icache, dcache, and future ports) and the single shared memory bus. Each port issues one line read or line write at a time. The arbiter holds at most one memory transaction outstanding, selects the winner by fixed priority or round-robin, and routes the memory response back to the granted port. It replaces the fixed two-port arbiter in the top level and adds write arbitration, a round-robin mode and a grant/busy status.

## Interface
Parameters:
- NUM_PORTS, 2: number of requester ports; must be ≥2.
- ADDR_SIZE, 32: address width.
- LINE_SIZE, 256: line data width in bits.
- RR_MODE, 1: 1 selects round-robin arbitration; 0 selects fixed priority, where port 0 is highest.

Ports (GW = $clog2(NUM_PORTS)):
- clk_i  in  1  clock; all logic is on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- port_req_valid_i  in  NUM_PORTS  per-port request valid.
- port_req_write_i  in  NUM_PORTS  per-port request type: 1 = line write, 0 = line read.
- port_req_addr_i  in  NUM_PORTS*ADDR_SIZE  per-port line address; port k occupies slice k.
- port_req_wdata_i  in  NUM_PORTS*LINE_SIZE  per-port write line.
- port_req_ready_o  out  NUM_PORTS  per-port request accepted; one-hot or zero.
- port_rsp_valid_o  out  NUM_PORTS  per-port response strobe; one-hot or zero.
- port_rsp_rdata_o  out  LINE_SIZE  read line, shared by all ports; qualified by port_rsp_valid_o.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_write_o  out  1  memory request type.
- mem_req_addr_o  out  ADDR_SIZE  memory request address.
- mem_req_wdata_o  out  LINE_SIZE  memory write line.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_rsp_valid_i  in  1  memory response; issued for both reads and writes (write acknowledge).
- mem_rsp_rdata_i  in  LINE_SIZE  memory read line.
- grant_o  out  GW  index of the current or last granted port.
- busy_o  out  1  high whenever the arbiter is not in IDLE.

## Operation
- State machine: IDLE, ISSUE, WAIT_RSP.
- **IDLE, arbitration:**
  - Fixed priority: the lowest-index requesting port wins.
  - Round-robin: the first requesting port at or after rr_ptr wins, searching upward with wrap-around.
- **IDLE, on a winner g:**
  - port_req_ready_o[g]=1 combinationally in the same cycle.
  - The request's write flag, address and wdata are latched into internal registers.
  - grant_o is loaded with g; next state is ISSUE.
- **IDLE, no request:** stay in IDLE.
- **ISSUE:**
  - mem_req_* are driven from the latched registers; mem_req_valid_o=1.
  - Stay in ISSUE until mem_req_ready_i=1.
  - Then go to WAIT_RSP. If mem_rsp_valid_i is also 1 in that cycle, complete directly instead (see completion).
- **WAIT_RSP:**
  - mem_req_valid_o=0.
  - On mem_rsp_valid_i=1: port_rsp_valid_o[g]=1 for exactly that cycle, port_rsp_rdata_o=mem_rsp_rdata_i, and the transaction completes.
- **Completion:**
  - Next state is IDLE.
  - In round-robin mode, rr_ptr <= (g+1) mod NUM_PORTS; the wrap is explicit, so non-power-of-two NUM_PORTS is legal.
  - In fixed-priority mode, rr_ptr is unused and stays 0.
- port_rsp_rdata_o passes mem_rsp_rdata_i through unconditionally. Ports must sample it only when their port_rsp_valid_o bit is high.
- Requests arriving while busy are ignored; ports hold valid until they see their ready bit.
- A port must not deassert valid or change its request before ready; the arbiter does not detect violations.
- mem_rsp_valid_i while in IDLE is ignored; it produces no port strobe.

## Timing
- **Reset (reset_i=0, async):**
  - State=IDLE, rr_ptr=0, grant_o=0, busy_o=0.
  - mem_req_valid_o=0; mem_req_write_o, addr and wdata = 0.
  - All port_req_ready_o and port_rsp_valid_o = 0.
- Reset mid-transaction aborts it. No response is delivered and memory-side cleanup is the system's responsibility.
- Latency, with an immediately ready memory that returns data R cycles after accept:
  - Port accept: cycle 0.
  - mem_req_valid_o: cycle 1.
  - Port response: cycle 1+R.
  - Next grant: earliest cycle 2+R.
- Back-to-back: one IDLE cycle between transactions is mandatory.
- Outputs mem_req_*, grant_o and busy_o are registered. port_req_ready_o and port_rsp_valid_o are combinational from state and inputs.

## Test plan
- **Single read:** port 1 reads addr 0x100 and memory returns 0xA5…A5 after 5 cycles -> ready[1] at cycle 0, mem_req_valid at 1, rsp_valid[1] with 0xA5…A5 at 6, grant_o=1.
- **Round-robin, NUM_PORTS=3:** all three ports request continuously -> grant order 0,1,2,0,1,2, with exactly one IDLE cycle between transactions.
- **Fixed priority (RR_MODE=0):** ports 0 and 1 request continuously -> port 0 always wins and port 1 is starved.
- **Write:** port 0 writes line 0xDEAD… to 0x40, memory holds mem_req_ready_i=0 for 3 cycles -> mem_req_* stable for 4 cycles with write=1; the ack raises rsp_valid[0].
- **Same-cycle accept and response:** mem_req_ready_i and mem_rsp_valid_i high in the same cycle -> rsp_valid[g] in that cycle, IDLE next cycle.
- **Async reset during WAIT_RSP:** reset asserted -> all outputs 0 immediately; a later mem_rsp_valid_i produces no port strobe; rr_ptr restarts at port 0.
